// File: rtl/sbox_share_ctrl_if.sv
// Request/response bundle between the round datapath, the key schedule and the
// shared SubBytes lane.
interface sbox_share_ctrl_if;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_in;
  logic [127:0] st_out;
  logic         st_out_valid;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw_in;
  logic [31:0]  kw_out;
  logic         kw_out_valid;
  logic         busy;

  modport master (
    output st_valid, st_in, kw_valid, kw_in,
    input  st_ready, st_out, st_out_valid, kw_ready, kw_out, kw_out_valid, busy
  );

  modport slave (
    input  st_valid, st_in, kw_valid, kw_in,
    output st_ready, st_out, st_out_valid, kw_ready, kw_out, kw_out_valid, busy
  );
endinterface

// File: rtl/sbox_share_ctrl.sv
// Shared 32-bit AES S-box lane: arbitrates 128-bit SubBytes (four beats) against
// single-beat SubWord requests and assembles the substituted results.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  // Byte 0x00 sits in the top byte, so entry a lives at bit offset 8*(255-a).
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign c = TBL[{~a, 3'b000} +: 8];
endmodule

module sbox_share_ctrl #(
  parameter bit RR_ARB = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  sbox_share_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ST_BEAT, KW_BEAT} state_t;
  typedef enum logic {PTR_KEY, PTR_ST} ptr_t;

  state_t       state;
  ptr_t         ptr;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [31:0]  lane_in;
  logic [31:0]  lane_out;
  logic         idle;
  logic         both;
  logic         key_wins;
  logic         st_fire;
  logic         kw_fire;

  // A ready is only withheld from the loser of a contested grant.
  assign idle     = (state == IDLE) && !rst;
  assign both     = bus.st_valid && bus.kw_valid;
  assign key_wins = !RR_ARB || (ptr == PTR_KEY);

  assign bus.st_ready = idle && !(both && key_wins);
  assign bus.kw_ready = idle && !(both && !key_wins);
  assign st_fire      = bus.st_valid && bus.st_ready;
  assign kw_fire      = bus.kw_valid && bus.kw_ready;

  // Key words reuse the top word of the state working register.
  always_ff @(posedge clk) begin
    if (st_fire)      work         <= bus.st_in;
    else if (kw_fire) work[127:96] <= bus.kw_in;
  end

  always_comb begin
    lane_in = '0;
    if (state == ST_BEAT) begin
      case (cnt)
        2'd0:    lane_in = work[127:96];
        2'd1:    lane_in = work[95:64];
        2'd2:    lane_in = work[63:32];
        default: lane_in = work[31:0];
      endcase
    end else if (state == KW_BEAT) begin
      lane_in = work[127:96];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sbox u_sbox (.a(lane_in[8*i +: 8]), .c(lane_out[8*i +: 8]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= PTR_KEY;
      cnt              <= 2'd0;
      bus.st_out       <= '0;
      bus.kw_out       <= '0;
      bus.st_out_valid <= 1'b0;
      bus.kw_out_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.st_out_valid <= 1'b0;
      bus.kw_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (kw_fire) begin
            state    <= KW_BEAT;
            ptr      <= PTR_ST;
            bus.busy <= 1'b1;
          end else if (st_fire) begin
            state    <= ST_BEAT;
            ptr      <= PTR_KEY;
            cnt      <= 2'd0;
            bus.busy <= 1'b1;
          end
        end
        ST_BEAT: begin
          case (cnt)
            2'd0:    bus.st_out[127:96] <= lane_out;
            2'd1:    bus.st_out[95:64]  <= lane_out;
            2'd2:    bus.st_out[63:32]  <= lane_out;
            default: bus.st_out[31:0]   <= lane_out;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state            <= IDLE;
            bus.st_out_valid <= 1'b1;
            bus.busy         <= 1'b0;
          end
        end
        KW_BEAT: begin
          bus.kw_out       <= lane_out;
          bus.kw_out_valid <= 1'b1;
          state            <= IDLE;
          bus.busy         <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_sbox_share_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbox_share_ctrl_if bus();
  sbox_share_ctrl_if bus0();

  sbox_share_ctrl #(.RR_ARB(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  sbox_share_ctrl #(.RR_ARB(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  int passed = 0;
  int total  = 0;
  int failed = 0;

  localparam logic [127:0] ST_X   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST_Y   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO_Y = {16{8'h63}};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_op(input string tag, input logic [31:0] din, input logic [31:0] exp);
    bus.kw_in    = din;
    bus.kw_valid = 1'b1;
    tick();
    bus.kw_valid = 1'b0;
    chk1({tag, "_busy"}, bus.busy, 1'b1);
    chk1({tag, "_early_vld"}, bus.kw_out_valid, 1'b0);
    tick();
    chk1({tag, "_vld"}, bus.kw_out_valid, 1'b1);
    chk32({tag, "_data"}, bus.kw_out, exp);
    chk1({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.st_valid  = 1'b0; bus.kw_valid  = 1'b0; bus.st_in  = '0; bus.kw_in  = '0;
    bus0.st_valid = 1'b0; bus0.kw_valid = 1'b0; bus0.st_in = '0; bus0.kw_in = '0;
    tick();
    tick();
    chk1("rst_st_ready", bus.st_ready, 1'b0);
    chk1("rst_kw_ready", bus.kw_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk128("rst_st_out", bus.st_out, '0);
    chk32("rst_kw_out", bus.kw_out, '0);
    chk1("rst_st_vld", bus.st_out_valid, 1'b0);
    chk1("rst_kw_vld", bus.kw_out_valid, 1'b0);
    chk1("rst0_kw_ready", bus0.kw_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("idle_st_ready", bus.st_ready, 1'b1);
    chk1("idle_kw_ready", bus.kw_ready, 1'b1);

    // Single state op with a one-cycle valid pulse; input scrambled after accept.
    bus.st_in    = ST_X;
    bus.st_valid = 1'b1;
    tick();
    bus.st_valid = 1'b0;
    bus.st_in    = '1;
    chk1("st1_busy_k", bus.busy, 1'b1);
    chk1("st1_ready_busy", bus.st_ready, 1'b0);
    chk1("st1_vld_k", bus.st_out_valid, 1'b0);
    tick();
    tick();
    tick();
    chk1("st1_vld_k3", bus.st_out_valid, 1'b0);
    chk1("st1_busy_k3", bus.busy, 1'b1);
    tick();
    chk1("st1_vld_k4", bus.st_out_valid, 1'b1);
    chk128("st1_data", bus.st_out, ST_Y);
    chk1("st1_busy_k4", bus.busy, 1'b0);
    tick();
    chk1("st1_vld_k5", bus.st_out_valid, 1'b0);
    chk128("st1_hold", bus.st_out, ST_Y);

    key_op("kw_a", 32'hcf4f3c09, 32'h8a84eb01);
    key_op("kw_b", 32'h00000000, 32'h63636363);
    key_op("kw_c", 32'hff53017c, 32'h16ed7c10);

    // State request arriving during a key op waits, then runs back-to-back.
    bus.kw_in    = 32'hcf4f3c09;
    bus.kw_valid = 1'b1;
    tick();
    bus.kw_valid = 1'b0;
    bus.st_in    = ST_X;
    bus.st_valid = 1'b1;
    #1;
    chk1("bp_st_ready_kw", bus.st_ready, 1'b0);
    tick();
    chk1("bp_kw_vld", bus.kw_out_valid, 1'b1);
    chk1("bp_st_ready_idle", bus.st_ready, 1'b1);
    tick();
    bus.st_in = '0;
    chk1("bp_vld_a0", bus.st_out_valid, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk1("bp_vld_a", bus.st_out_valid, 1'b1);
    chk128("bp_data_a", bus.st_out, ST_Y);
    tick();
    bus.st_valid = 1'b0;
    chk1("bp_vld_b0", bus.st_out_valid, 1'b0);
    tick();
    tick();
    tick();
    chk1("bp_vld_b3", bus.st_out_valid, 1'b0);
    tick();
    chk1("bp_vld_b", bus.st_out_valid, 1'b1);
    chk128("bp_data_b", bus.st_out, ZERO_Y);

    // Reset two edges into a state op.
    bus.st_in    = ST_X;
    bus.st_valid = 1'b1;
    tick();
    bus.st_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mr_vld", bus.st_out_valid, 1'b0);
    chk128("mr_st_out", bus.st_out, '0);
    chk32("mr_kw_out", bus.kw_out, '0);
    chk1("mr_busy", bus.busy, 1'b0);
    tick();
    tick();
    chk1("mr_vld_late", bus.st_out_valid, 1'b0);

    // Round-robin with both requesters held: K,S,K,S.
    bus.st_in    = ST_X;
    bus.kw_in    = 32'hcf4f3c09;
    bus.st_valid = 1'b1;
    bus.kw_valid = 1'b1;
    #1;
    chk1("rr1_kw_ready", bus.kw_ready, 1'b1);
    chk1("rr1_st_ready", bus.st_ready, 1'b0);
    tick();
    chk1("rr1_busy", bus.busy, 1'b1);
    tick();
    chk1("rr1_kw_vld", bus.kw_out_valid, 1'b1);
    chk32("rr1_kw_data", bus.kw_out, 32'h8a84eb01);
    chk1("rr2_st_ready", bus.st_ready, 1'b1);
    chk1("rr2_kw_ready", bus.kw_ready, 1'b0);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk1("rr2_st_vld", bus.st_out_valid, 1'b1);
    chk128("rr2_st_data", bus.st_out, ST_Y);
    chk1("rr3_kw_ready", bus.kw_ready, 1'b1);
    chk1("rr3_st_ready", bus.st_ready, 1'b0);
    bus.kw_in = 32'h00000000;
    bus.st_in = '0;
    tick();
    tick();
    chk1("rr3_kw_vld", bus.kw_out_valid, 1'b1);
    chk32("rr3_kw_data", bus.kw_out, 32'h63636363);
    chk1("rr4_st_ready", bus.st_ready, 1'b1);
    tick();
    bus.st_valid = 1'b0;
    bus.kw_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk1("rr4_st_vld", bus.st_out_valid, 1'b1);
    chk128("rr4_st_data", bus.st_out, ZERO_Y);

    // Fixed priority: key first, state in the IDLE cycle after kw_out_valid.
    bus0.st_in    = ST_X;
    bus0.kw_in    = 32'hff53017c;
    bus0.st_valid = 1'b1;
    bus0.kw_valid = 1'b1;
    #1;
    chk1("fp_kw_ready", bus0.kw_ready, 1'b1);
    chk1("fp_st_ready", bus0.st_ready, 1'b0);
    tick();
    bus0.kw_valid = 1'b0;
    tick();
    chk1("fp_kw_vld", bus0.kw_out_valid, 1'b1);
    chk32("fp_kw_data", bus0.kw_out, 32'h16ed7c10);
    chk1("fp_st_ready_after", bus0.st_ready, 1'b1);
    tick();
    bus0.st_valid = 1'b0;
    tick();
    tick();
    tick();
    chk1("fp_st_vld_early", bus0.st_out_valid, 1'b0);
    tick();
    chk1("fp_st_vld", bus0.st_out_valid, 1'b1);
    chk128("fp_st_data", bus0.st_out, ST_Y);

    #1;
    chk1("end_st_ready", bus.st_ready, 1'b1);
    chk1("end_kw_ready", bus.kw_ready, 1'b1);

    if (failed != 0) $display("%0d comparisons did not match", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
